// File: rtl/tpu_matmul_sequencer.sv
// tpu_matmul_sequencer: job-level controller for the systolic datapath.
// One accepted start runs a full tile: pop a weight set, pulse weight reload,
// stream MATRIX_SIZE unified-buffer rows, wait out the array pipeline, then
// write MATRIX_SIZE result rows and pulse done.
// Optional feature: define TPU_SEQ_PERF_CNT_EN to add the job_cycles output,
// a saturating count of busy cycles for the most recent job.
`timescale 1ns/1ps

module tpu_matmul_sequencer #(
    parameter int ADDRESSSIZE  = 10,
    parameter int MATRIX_SIZE  = 32,
    parameter int PIPE_LATENCY = 96,
    parameter int CNT_W        = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [ADDRESSSIZE-1:0] ub_base,
    input  logic [ADDRESSSIZE-1:0] res_base,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    output logic                   we_rl,
    output logic [ADDRESSSIZE-1:0] ub_address,
    output logic                   ub_valid,
    output logic                   res_write_enable,
    output logic [ADDRESSSIZE-1:0] res_address,
    output logic                   busy,
    output logic                   done,
    output logic                   err_no_weight
`ifdef TPU_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]            job_cycles
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_RELOAD,
        ST_STREAM,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] ROWS        = CNT_W'(MATRIX_SIZE);
    localparam logic [CNT_W-1:0] WAIT_CYCLES = CNT_W'(PIPE_LATENCY - MATRIX_SIZE);
    localparam bit               ZERO_WAIT   = (PIPE_LATENCY == MATRIX_SIZE);

    state_t                 state;
    logic [ADDRESSSIZE-1:0] ub_base_q;
    logic [ADDRESSSIZE-1:0] res_base_q;
    logic [CNT_W-1:0]       cnt;
    logic                   accept;

    // A start is taken in IDLE, or in DONE so that a held start reissues with no bubble
    assign accept = ((state == ST_IDLE) || (state == ST_DONE)) && start && !fifo_empty;

    // Main sequencing FSM; every output is registered and asserted in the cycle of its state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= ST_IDLE;
            ub_base_q        <= '0;
            res_base_q       <= '0;
            cnt              <= '0;
            fifo_read_enable <= 1'b0;
            we_rl            <= 1'b0;
            ub_address       <= '0;
            ub_valid         <= 1'b0;
            res_write_enable <= 1'b0;
            res_address      <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err_no_weight    <= 1'b0;
        end else begin
            fifo_read_enable <= 1'b0;
            we_rl            <= 1'b0;
            ub_valid         <= 1'b0;
            res_write_enable <= 1'b0;
            done             <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        ub_base_q        <= ub_base;
                        res_base_q       <= res_base;
                        err_no_weight    <= 1'b0;
                        cnt              <= '0;
                        busy             <= 1'b1;
                        fifo_read_enable <= 1'b1;
                        state            <= ST_POP;
                    end else begin
                        if (start) begin
                            err_no_weight <= 1'b1;
                        end
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_POP: begin
                    we_rl <= 1'b1;
                    state <= ST_RELOAD;
                end
                ST_RELOAD: begin
                    ub_valid   <= 1'b1;
                    ub_address <= ub_base_q;
                    cnt        <= CNT_W'(1);
                    state      <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (cnt == ROWS) begin
                        cnt <= CNT_W'(1);
                        if (ZERO_WAIT) begin
                            res_write_enable <= 1'b1;
                            res_address      <= res_base_q;
                            state            <= ST_WRITE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end else begin
                        ub_valid   <= 1'b1;
                        ub_address <= ub_base_q + ADDRESSSIZE'(cnt);
                        cnt        <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (cnt == WAIT_CYCLES) begin
                        res_write_enable <= 1'b1;
                        res_address      <= res_base_q;
                        cnt              <= CNT_W'(1);
                        state            <= ST_WRITE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (cnt == ROWS) begin
                        done  <= 1'b1;
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else begin
                        res_write_enable <= 1'b1;
                        res_address      <= res_base_q + ADDRESSSIZE'(cnt);
                        cnt              <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TPU_SEQ_PERF_CNT_EN
    // Busy-cycle counter: cleared on accept, saturating, and frozen once the job returns to IDLE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            job_cycles <= '0;
        end else if (accept) begin
            job_cycles <= '0;
        end else if (busy && (job_cycles != 16'hFFFF)) begin
            job_cycles <= job_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tpu_matmul_sequencer.sv
// tb_tpu_matmul_sequencer: randomized and directed stimulus for two sequencer
// instances (PIPE_LATENCY 10 and 4, MATRIX_SIZE 4) against a job-timeline model.
`timescale 1ns/1ps

module tb_tpu_matmul_sequencer;

    localparam int AW = 10;
    localparam int M  = 4;
    localparam int CW = 8;
    localparam int P0 = 10;
    localparam int P1 = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          fifo_empty;
    logic [AW-1:0] ub_base;
    logic [AW-1:0] res_base;

    logic          fre_o  [2];
    logic          werl_o [2];
    logic [AW-1:0] uba_o  [2];
    logic          ubv_o  [2];
    logic          rwe_o  [2];
    logic [AW-1:0] rsa_o  [2];
    logic          busy_o [2];
    logic          done_o [2];
    logic          err_o  [2];
`ifdef TPU_SEQ_PERF_CNT_EN
    logic [15:0]   jc_o   [2];
`endif

    int            cyc;
    int            acc      [2];
    bit            active   [2];
    logic [AW-1:0] ubb      [2];
    logic [AW-1:0] rsb      [2];
    logic [AW-1:0] last_ub  [2];
    logic [AW-1:0] last_res [2];
    bit            err_m    [2];
    int            jc_exp   [2];
    bit            jc_known [2];
    int            n_checks;
    int            n_fail;

    always #5 clk = ~clk;

    tpu_matmul_sequencer #(
        .ADDRESSSIZE(AW), .MATRIX_SIZE(M), .PIPE_LATENCY(P0), .CNT_W(CW)
    ) dut0 (
        .clk(clk), .rstn(rstn), .start(start), .ub_base(ub_base), .res_base(res_base),
        .fifo_empty(fifo_empty), .fifo_read_enable(fre_o[0]), .we_rl(werl_o[0]),
        .ub_address(uba_o[0]), .ub_valid(ubv_o[0]), .res_write_enable(rwe_o[0]),
        .res_address(rsa_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .err_no_weight(err_o[0])
`ifdef TPU_SEQ_PERF_CNT_EN
        , .job_cycles(jc_o[0])
`endif
    );

    tpu_matmul_sequencer #(
        .ADDRESSSIZE(AW), .MATRIX_SIZE(M), .PIPE_LATENCY(P1), .CNT_W(CW)
    ) dut1 (
        .clk(clk), .rstn(rstn), .start(start), .ub_base(ub_base), .res_base(res_base),
        .fifo_empty(fifo_empty), .fifo_read_enable(fre_o[1]), .we_rl(werl_o[1]),
        .ub_address(uba_o[1]), .ub_valid(ubv_o[1]), .res_write_enable(rwe_o[1]),
        .res_address(rsa_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .err_no_weight(err_o[1])
`ifdef TPU_SEQ_PERF_CNT_EN
        , .job_cycles(jc_o[1])
`endif
    );

    function automatic int plat(input int k);
        return (k == 0) ? P0 : P1;
    endfunction

    // Offset from the accept cycle to the done cycle
    function automatic int done_rel(input int k);
        return 3 + plat(k) + M;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            active[k]   = 1'b0;
            err_m[k]    = 1'b0;
            last_ub[k]  = '0;
            last_res[k] = '0;
            jc_known[k] = 1'b1;
            jc_exp[k]   = 0;
        end
    endtask

    // Job-level model update for the clock edge that ends cycle 'cyc'
    task automatic modelEdge(input int k);
        int rel;
        bit can;
        rel = cyc - acc[k];
        can = !active[k] || (rel == done_rel(k));
        if (can && start && !fifo_empty) begin
            active[k]   = 1'b1;
            acc[k]      = cyc;
            ubb[k]      = ub_base;
            rsb[k]      = res_base;
            err_m[k]    = 1'b0;
            jc_known[k] = 1'b0;
        end else begin
            if (can && start) err_m[k] = 1'b1;
            if (active[k] && (rel == done_rel(k))) begin
                active[k]   = 1'b0;
                jc_known[k] = 1'b1;
                jc_exp[k]   = plat(k) + M + 3;
            end
        end
    endtask

    task automatic checkInstance(input int k);
        int rel;
        bit a, e_pop, e_rl, e_uv, e_wr, e_done;
        string p;
        p    = $sformatf("p%0d", plat(k));
        rel  = cyc - acc[k];
        a    = active[k];
        e_pop  = a && (rel == 1);
        e_rl   = a && (rel == 2);
        e_uv   = a && (rel >= 3) && (rel < 3 + M);
        e_wr   = a && (rel >= 3 + plat(k)) && (rel < 3 + plat(k) + M);
        e_done = a && (rel == done_rel(k));
        if (e_uv) last_ub[k]  = ubb[k] + AW'(rel - 3);
        if (e_wr) last_res[k] = rsb[k] + AW'(rel - 3 - plat(k));
        checkOutput({p, " fifo_read_enable"}, 32'(fre_o[k]),  32'(e_pop));
        checkOutput({p, " we_rl"},            32'(werl_o[k]), 32'(e_rl));
        checkOutput({p, " ub_valid"},         32'(ubv_o[k]),  32'(e_uv));
        checkOutput({p, " ub_address"},       32'(uba_o[k]),  32'(last_ub[k]));
        checkOutput({p, " res_write_enable"}, 32'(rwe_o[k]),  32'(e_wr));
        checkOutput({p, " res_address"},      32'(rsa_o[k]),  32'(last_res[k]));
        checkOutput({p, " busy"},             32'(busy_o[k]), 32'(a));
        checkOutput({p, " done"},             32'(done_o[k]), 32'(e_done));
        checkOutput({p, " err_no_weight"},    32'(err_o[k]),  32'(err_m[k]));
`ifdef TPU_SEQ_PERF_CNT_EN
        if (!a && jc_known[k]) checkOutput({p, " job_cycles"}, 32'(jc_o[k]), 32'(jc_exp[k]));
`endif
    endtask

    // Drive one cycle of inputs, clock it, advance the model and check both instances
    task automatic applyStimulus(input bit s, input bit e, input logic [AW-1:0] ub, input logic [AW-1:0] rs);
        start      = s;
        fifo_empty = e;
        ub_base    = ub;
        res_base   = rs;
        @(posedge clk);
        if (rstn) begin
            modelEdge(0);
            modelEdge(1);
        end
        cyc++;
        #1;
        checkInstance(0);
        checkInstance(1);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0);
    endtask

    // Asynchronous reset asserted between clock edges, held for two edges, released away from an edge
    task automatic midReset();
        rstn = 1'b0;
        modelReset();
        #1;
        checkInstance(0);
        checkInstance(1);
        idleCycles(2);
        #3;
        rstn = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        acc[0]   = 0;
        acc[1]   = 0;
        ubb[0]   = '0;
        ubb[1]   = '0;
        rsb[0]   = '0;
        rsb[1]   = '0;
        rstn       = 1'b0;
        start      = 1'b0;
        fifo_empty = 1'b0;
        ub_base    = '0;
        res_base   = '0;
        modelReset();
        #1;
        checkInstance(0);
        checkInstance(1);
        idleCycles(2);
        #3;
        rstn = 1'b1;
        idleCycles(2);

        $display("[TB] basic job");
        applyStimulus(1'b1, 1'b0, 10'd5, 10'd20);
        idleCycles(20);

        $display("[TB] empty weight FIFO then recovery");
        applyStimulus(1'b1, 1'b1, 10'd7, 10'd9);
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, 10'd7, 10'd9);
        idleCycles(20);

        $display("[TB] address wrap");
        applyStimulus(1'b1, 1'b0, 10'd1022, 10'd1023);
        idleCycles(20);

        $display("[TB] start while busy");
        applyStimulus(1'b1, 1'b0, 10'd100, 10'd200);
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, 10'd300, 10'd400);
        idleCycles(20);

        $display("[TB] back-to-back with start held");
        for (int i = 0; i < 2 * (3 + P0 + M) + 3; i++)
            applyStimulus(1'b1, 1'b0, 10'(i * 3), 10'(500 + i));
        idleCycles(20);

        $display("[TB] reset during write row 2");
        applyStimulus(1'b1, 1'b0, 10'd40, 10'd60);
        idleCycles(3 + P0 + 2 - 1);
        midReset();
        idleCycles(20);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) midReset();
            applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                          AW'($urandom_range(0, 1023)), AW'($urandom_range(0, 1023)));
        end
        idleCycles(25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
